// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and future receiver.
// FSM encodings, parity selects and frame sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Number of bit times in one frame.
    function automatic int frame_len(
        input int width,
        input int parity_en,
        input int stop_bits
    );
        return 1 + width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter producing one bit_tick per bit time.
// clear restarts the bit time so the first tick lands CLKS_PER_BIT cycles later.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);
    import uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..CLKS_PER_BIT-1, wrapping at every bit boundary.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and sends them as UART frames.
// Start bit, data LSB first, optional parity, then 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    import uart_pkg::*;

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic PAR_SEL =
        (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BW-1:0]    bit_q;
    logic [BW-1:0]    bit_d;
    logic             par_q;
    logic             par_d;
    logic             tx_q;
    logic             tx_d;
    logic             done_q;
    logic             done_d;
    logic             bit_tick;
    logic             timer_clr;

    // The bit time restarts as the FSM enters START.
    assign timer_clr = (state_q == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clr),
        .bit_tick (bit_tick)
    );

    // Next-state, shift register, parity and line value for the next cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = fifo_rd_data;
                par_d   = (PAR_SEL == uart_pkg::PARITY_ODD) ?
                          ~^fifo_rd_data : ^fifo_rd_data;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it follows the state being entered.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx.
// Four instances cover plain, even/odd parity and two-stop-bit frames.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int ND  = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic tx_en  = 1'b0;

    logic       empty_w [ND];
    logic       rd_en_w [ND];
    logic [7:0] rdd     [ND];
    logic       tx_w    [ND];
    logic       busy_w  [ND];
    logic       fd_w    [ND];

    logic [7:0] fmem [ND][16];
    logic [7:0] emem [ND][16];
    int wp   [ND];
    int rp   [ND];
    int ewp  [ND];
    int erp  [ND];
    int gap3 [ND];

    int pop_err = 0;
    int cyc     = 0;
    int total   = 0;
    int bad     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @* begin
        for (int d = 0; d < ND; d++) empty_w[d] = (rp[d] == wp[d]);
    end

    // FIFO model: registered read port, data valid the cycle after rd_en.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rd_en_w[d] === 1'b1) begin
                if (rp[d] == wp[d]) begin
                    pop_err <= pop_err + 1;
                end else begin
                    rdd[d] <= fmem[d][rp[d] % 16];
                    rp[d]  <= rp[d] + 1;
                end
            end
        end
    end

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(1)) u_base (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[0]),
        .fifo_rd_en(rd_en_w[0]), .fifo_rd_data(rdd[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .frame_done(fd_w[0]));

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                   .PARITY_ODD(0), .STOP_BITS(1)) u_peven (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[1]),
        .fifo_rd_en(rd_en_w[1]), .fifo_rd_data(rdd[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .frame_done(fd_w[1]));

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                   .PARITY_ODD(1), .STOP_BITS(1)) u_podd (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[2]),
        .fifo_rd_en(rd_en_w[2]), .fifo_rd_data(rdd[2]), .tx(tx_w[2]),
        .busy(busy_w[2]), .frame_done(fd_w[2]));

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(empty_w[3]),
        .fifo_rd_en(rd_en_w[3]), .fifo_rd_data(rdd[3]), .tx(tx_w[3]),
        .busy(busy_w[3]), .frame_done(fd_w[3]));

    function automatic int par_en(input int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction

    function automatic int nbits(input int d);
        return (d == 0) ? 10 : 11;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[dut%0d]: got %0d, expected %0d (cycle %0d)",
                     name, d, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [7:0] v);
        fmem[d][wp[d] % 16] = v;
        wp[d] = wp[d] + 1;
        emem[d][ewp[d] % 16] = v;
        ewp[d] = ewp[d] + 1;
    endtask

    // Monitor: follows each frame cycle by cycle against the queued word.
    task automatic mon(input int d);
        bit         inf  = 1'b0;
        int         k    = 0;
        int         mism = 0;
        int         rdc  = -100;
        int         ecyc = -100;
        logic [15:0] efr = '1;
        logic [7:0]  ed  = '0;
        logic [7:0]  rx  = '0;
        logic [3:0]  bi;
        logic [2:0]  ri;
        forever begin
            @(negedge clk);
            if (rd_en_w[d] === 1'b1) rdc = cyc;
            if (rst) begin
                if (inf) begin
                    inf = 1'b0;
                    erp[d] = erp[d] + 1;
                end
            end else begin
                if (!inf && tx_w[d] === 1'b0) begin
                    chk("frame_queued", d, (ewp[d] > erp[d]) ? 1 : 0, 1);
                    ed = emem[d][erp[d] % 16];
                    efr = '1;
                    efr[0] = 1'b0;
                    efr[8:1] = ed;
                    if (par_en(d) != 0) efr[9] = (d == 2) ? ~^ed : ^ed;
                    chk("start_latency", d, cyc - rdc, 2);
                    if (cyc - ecyc - 1 == 3) gap3[d]++;
                    inf = 1'b1;
                    k = 0;
                    mism = 0;
                    rx = '0;
                end
                if (inf) begin
                    if (k < nbits(d) * CPB) begin
                        bi = 4'(k / CPB);
                        if (tx_w[d] !== efr[bi] || busy_w[d] !== 1'b1 ||
                            fd_w[d] !== 1'b0) mism++;
                        if (k % CPB == CPB / 2 && k >= CPB && k < 9 * CPB) begin
                            ri = 3'(k / CPB - 1);
                            rx[ri] = tx_w[d];
                        end
                        k++;
                    end else begin
                        chk("frame_data", d, int'(rx), int'(ed));
                        chk("frame_wave", d, mism, 0);
                        chk("frame_done_idle", d, {30'b0, fd_w[d], busy_w[d]}, 2);
                        ecyc = cyc - 1;
                        inf = 1'b0;
                        erp[d] = erp[d] + 1;
                    end
                end
            end
        end
    endtask

    task automatic wait_start(input int d);
        int n = 0;
        while (tx_w[d] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout", d, (n < 200) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((erp[d] != ewp[d] || busy_w[d] !== 1'b0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", d, (n < 600) ? 1 : 0, 1);
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [9:0] v1;
        int r0;
        int g0;
        int hi;
        int lows;

        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_tx", d, int'(tx_w[d]), 1);
            chk("rst_busy", d, int'(busy_w[d]), 0);
            chk("rst_rd_en", d, int'(rd_en_w[d]), 0);
            chk("rst_done", d, int'(fd_w[d]), 0);
        end
        rst = 1'b0;
        tx_en = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 on the plain instance, hand-checked bit by bit.
        push(0, 8'hA5);
        wait_start(0);
        v1 = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? 2 : 4) @(negedge clk);
            chk("t1_bit", 0, int'(tx_w[0]), int'(v1[0]));
            v1 = v1 >> 1;
        end
        wait_idle(0);
        chk("t1_pops", 0, rp[0], 1);

        // Three back-to-back words, then a drained FIFO.
        r0 = rp[0];
        g0 = gap3[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        wait_idle(0);
        chk("t2_pops", 0, rp[0] - r0, 3);
        chk("t2_gap3", 0, gap3[0] - g0, 2);
        repeat (20) @(negedge clk);
        chk("t2_no_pop_empty", 0, rp[0] - r0, 3);
        chk("t2_tx_idle", 0, int'(tx_w[0]), 1);

        // Parity bit for 0x07: even -> 1, odd -> 0.
        push(1, 8'h07);
        push(2, 8'h07);
        wait_start(1);
        repeat (38) @(negedge clk);
        chk("t3_even_par", 1, int'(tx_w[1]), 1);
        chk("t3_odd_par", 2, int'(tx_w[2]), 0);
        wait_idle(1);
        wait_idle(2);

        // tx_en dropped during data bit 2 with two words queued.
        push(0, 8'h96);
        push(0, 8'h3E);
        wait_start(0);
        repeat (4 + 2 * 4 + 1) @(negedge clk);
        tx_en = 1'b0;
        r0 = rp[0];
        repeat (80) @(negedge clk);
        chk("t4_no_pop_disabled", 0, rp[0] - r0, 0);
        chk("t4_idle_disabled", 0, int'(busy_w[0]), 0);
        chk("t4_tx_high", 0, int'(tx_w[0]), 1);
        tx_en = 1'b1;
        wait_idle(0);
        chk("t4_resume_pop", 0, rp[0] - r0, 1);

        // Reset during data bit 3 drops the word; the next one goes out intact.
        r0 = rp[0];
        push(0, 8'hC3);
        push(0, 8'h81);
        wait_start(0);
        repeat (4 + 3 * 4 + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_tx", 0, int'(tx_w[0]), 1);
        chk("t5_busy", 0, int'(busy_w[0]), 0);
        chk("t5_rd_en", 0, int'(rd_en_w[0]), 0);
        rst = 1'b0;
        wait_idle(0);
        chk("t5_pops", 0, rp[0] - r0, 2);

        // Two stop bits: 8 high cycles, frame_done 44 cycles after START.
        r0 = rp[3];
        push(3, 8'h3C);
        wait_start(3);
        repeat (35) @(negedge clk);
        chk("t6_last_data", 3, int'(tx_w[3]), 0);
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_w[3] === 1'b1 && busy_w[3] === 1'b1) hi++;
            @(negedge clk);
        end
        chk("t6_stop_cycles", 3, hi, 8);
        chk("t6_done_at_44", 3, int'(fd_w[3]), 1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_w[3] !== 1'b1) lows++;
        end
        chk("t6_tx_idle_empty", 3, lows, 0);
        chk("t6_pops", 3, rp[3] - r0, 1);

        chk("pop_from_empty", 0, pop_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's synchronous FIFO. It pops one word at a time through the FIFO's registered read port and serialises each word onto a UART line: start bit, data LSB first, optional parity, 1 or 2 stop bits. It sits between a FIFO instance and the chip-level TX pin and gives the FIFO a paced drain.

Parameters:
WIDTH, 8, data bits per frame; must match the FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_en  input  1  permits new frames to start; a frame already in flight always completes.
fifo_empty  input  1  FIFO empty flag; registered and may lag by up to 2 cycles after the final pop.
fifo_rd_en  output  1  pop request to the FIFO; one-cycle pulse, one per frame.
fifo_rd_data  input  WIDTH  FIFO read data; valid on the cycle after fifo_rd_en.
tx  output  1  serial line; idles high; registered output.
busy  output  1  high whenever state != IDLE.
frame_done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE after the last stop bit.

Behaviour:
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0. FSM goes to IDLE; bit counter and baud counter clear to 0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if tx_en && !fifo_empty, go to FETCH; otherwise stay in IDLE. fifo_empty is sampled only in IDLE.
- FETCH: fifo_rd_en=1 for exactly this one cycle (Moore output). Next state is LOAD.
- LOAD: capture fifo_rd_data into the shift register; compute parity (even = ^data, odd = ~^data). Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit.
- PARITY: entered only if PARITY_EN=1; holds the parity bit for one bit time.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, the next state is IDLE and frame_done pulses.
- Latency: tx falls on the 3rd edge after the IDLE cycle that saw the start condition.
- Frame length: (1 + WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE, FETCH and LOAD add exactly 3 extra tx-high cycles between the last stop bit and the next start bit.
- Empty-lag safety: the next IDLE sample occurs at least 2*(WIDTH+2) cycles after a pop, so fifo_empty lag cannot cause a pop from an empty FIFO. The block never pops in any state other than FETCH.
- tx_en low mid-frame: the current frame completes and no new pop is issued. Transmission resumes from IDLE when tx_en returns high.
- tx_en low during FETCH or LOAD: the popped word is still transmitted. Popped data is never dropped except by reset.
- rst mid-frame: the in-flight word is discarded. On the next cycle tx=1, busy=0, and no pop is issued.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index counter: width $clog2(WIDTH+1).

Decomposition:
- uart_pkg holds: the FSM state encodings (localparams), the PARITY_EVEN/PARITY_ODD constants, and a frame_len(WIDTH, PARITY_EN, STOP_BITS) function shared with the future receiver.
- One sub-module, uart_bit_timer: baud counter that emits a 1-cycle bit_tick; its clear input is driven from the FSM on entry to START.
- Shift register, parity logic and FSM stay in fifo_uart_tx.

Test Plan:
1. CLKS_PER_BIT=4, FIFO preloaded with 0xA5 -> one fifo_rd_en pulse; tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; frame_done pulses 40 cycles after START.
2. FIFO holds 0x00, 0xFF, 0x55 -> exactly 3 pops and 3 correct frames, each separated by a 3-cycle gap; fifo_rd_en never asserts once the FIFO is drained.
3. PARITY_EN=1, data 0x07 -> parity bit 1 with even parity, 0 with odd parity; frame length 44 cycles.
4. tx_en dropped during DATA bit 2 with 2 words queued -> current frame completes; no pop while tx_en=0; second word sent after tx_en re-asserts.
5. rst pulsed during DATA bit 3 -> next cycle tx=1, busy=0, fifo_rd_en=0; after release, the next FIFO word is transmitted intact.
6. STOP_BITS=2, data 0x3C -> stop phase is 8 cycles high; frame_done at cycle 44; tx stays 1 while the FIFO is empty.
